// File: rtl/ram_pkg.sv
// Shared types and constants for the March C- RAM BIST: geometry, background patterns,
// element enum, and per-element direction/expected/write-data lookups.
package ram_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] BG0 = 8'h00;
  localparam logic [DATA_W-1:0] BG1 = 8'hFF;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_t;
  typedef enum logic {DIR_UP, DIR_DN} dir_t;

  function automatic dir_t elem_dir(input march_elem_t e);
    return (e == M3 || e == M4) ? DIR_DN : DIR_UP;
  endfunction

  function automatic march_elem_t next_elem(input march_elem_t e);
    case (e)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      default: return M5;
    endcase
  endfunction

  // Value the read half of an element expects to find.
  function automatic logic [DATA_W-1:0] elem_exp(input march_elem_t e);
    return (e == M2 || e == M4) ? BG1 : BG0;
  endfunction

  function automatic logic elem_writes(input march_elem_t e);
    return (e != M5);
  endfunction

  function automatic logic [DATA_W-1:0] elem_wdat(input march_elem_t e);
    return (e == M1 || e == M3) ? BG1 : BG0;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter with a terminal-address flag for the loaded direction.
// Latency: load/step take effect on the next edge; no backpressure.
module ram_bist_addr_gen
  import ram_pkg::*;
#(
  parameter int ADDR_W = ram_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  dir_t              load_dir,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  dir_t dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir  <= DIR_UP;
      addr <= '0;
    end else if (load) begin
      dir  <= load_dir;
      addr <= (load_dir == DIR_UP) ? '0 : '1;
    end else if (step) begin
      addr <= (dir == DIR_UP) ? addr + 1'b1 : addr - 1'b1;
    end
  end

  assign last = (dir == DIR_UP) ? (addr == '1) : (addr == '0);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST controller for a single-port synchronous-read RAM; stops at first miscompare.
// Latency: 177 cycles start-to-done for 16 words; start is ignored unless idle, no backpressure.
module ram_march_bist
  import ram_pkg::*;
#(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_MARCH, ST_DONE} fsm_t;

  fsm_t              state;
  march_elem_t       elem;
  logic              chk;
  logic              we_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] exp_dat;
  logic              mismatch;
  logic              ag_load;
  dir_t              ag_load_dir;
  logic              ag_step;
  logic              ag_last;

  assign exp_dat  = elem_exp(elem);
  assign mismatch = (state == ST_MARCH) && chk && (ram_dout != exp_dat);

  // The write paired with a CHK read is squashed in the very cycle the miscompare is seen,
  // so the faulty cell keeps its content for post-mortem.
  assign ram_we  = we_q & ~mismatch;
  assign ram_din = din_q & {DATA_W{ram_we}};

  always_comb begin
    ag_load     = 1'b0;
    ag_load_dir = DIR_UP;
    ag_step     = 1'b0;
    case (state)
      ST_IDLE: ag_load = start;
      ST_MARCH: begin
        if (elem == M0) begin
          ag_load = ag_last;
          ag_step = !ag_last;
        end else if (chk && !mismatch) begin
          ag_load     = ag_last && (elem != M5);
          ag_load_dir = elem_dir(next_elem(elem));
          ag_step     = !ag_last;
        end
      end
      default: ;
    endcase
  end

  ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .load_dir (ag_load_dir),
    .step     (ag_step),
    .addr     (ram_addr),
    .last     (ag_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      elem      <= M0;
      chk       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_MARCH;
            elem      <= M0;
            chk       <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
            we_q      <= 1'b1;
            din_q     <= BG0;
          end
        end
        ST_MARCH: begin
          if (elem == M0) begin
            if (ag_last) begin
              elem  <= M1;
              we_q  <= 1'b0;
              din_q <= '0;
            end
          end else if (!chk) begin
            chk   <= 1'b1;
            we_q  <= elem_writes(elem);
            din_q <= elem_writes(elem) ? elem_wdat(elem) : '0;
          end else if (mismatch) begin
            fail_addr <= ram_addr;
            fail_exp  <= exp_dat;
            fail_got  <= ram_dout;
            pass      <= 1'b0;
            state     <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            chk       <= 1'b0;
            we_q      <= 1'b0;
            din_q     <= '0;
          end else begin
            chk   <= 1'b0;
            we_q  <= 1'b0;
            din_q <= '0;
            if (ag_last) begin
              if (elem == M5) begin
                pass  <= 1'b1;
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                elem <= next_elem(elem);
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with a behavioural 16x8 RAM that can inject a stuck-at
// bit or a decoder alias.
module tb_ram_march_bist;
  import ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [3:0] fail_addr;
  logic [7:0] fail_exp, fail_got;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int n_vec = 0;
  int n_bad = 0;

  // RAM model state
  logic [7:0] mem [16];
  int         fault = 0;
  logic       init_req = 1'b0;
  int         wcnt = 0;
  int         nwr5 = 0;
  int         din_viol = 0;

  // Snapshot taken in cycle 1 of a run
  logic       s_pass1;
  logic [3:0] s_faddr1;
  logic [7:0] s_fexp1, s_fgot1;

  always #5 clk = ~clk;

  ram_march_bist #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always @(posedge clk) begin
    logic [7:0] rd;
    if (init_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h5A ^ 8'(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
      if (fault == 2 && ram_addr == 4'd3) mem[11] <= ram_din;
      wcnt <= wcnt + 1;
      if (ram_addr == 4'd5) nwr5 <= nwr5 + 1;
    end else begin
      rd = mem[ram_addr];
      if (fault == 1 && ram_addr == 4'd5) rd[0] = 1'b1;
      ram_dout <= rd;
    end
  end

  always @(negedge clk) begin
    if (rst_n && !ram_we && ram_din != 8'h00) din_viol <= din_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs 200 cycles after the accepted start, re-asserting start at cycles pa/pb.
  task automatic run_bist(input int pa, input int pb,
                          output int done_cyc, output int ndone, output int nbusy);
    done_cyc = -1;
    ndone    = 0;
    nbusy    = 0;
    start_pulse();
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      start = (i == pa || i == pb);
      if (i == 1) begin
        s_pass1  = pass;
        s_faddr1 = fail_addr;
        s_fexp1  = fail_exp;
        s_fgot1  = fail_got;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = i;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, nd, nb, w5, w0, nz;

    init_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 init_req = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_we", ram_we, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_din", ram_din, 0);
    check("rst_faddr", fail_addr, 0);
    check("rst_fexp", fail_exp, 0);
    check("rst_fgot", fail_got, 0);
    rst_n = 1'b1;

    // Fault-free run
    run_bist(0, 0, dc, nd, nb);
    check("ok_done_cyc", dc, 177);
    check("ok_ndone", nd, 1);
    check("ok_busy_cyc", nb, 176);
    check("ok_pass", pass, 1);
    check("ok_faddr", fail_addr, 0);
    check("ok_fexp", fail_exp, 0);
    check("ok_fgot", fail_got, 0);
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 8'h00) nz++;
    check("ok_mem_zero", nz, 0);

    // Bit 0 of address 5 stuck at 1
    fault = 1;
    w5 = nwr5;
    run_bist(0, 0, dc, nd, nb);
    check("sa1_done_cyc", dc, 29);
    check("sa1_pass", pass, 0);
    check("sa1_faddr", fail_addr, 5);
    check("sa1_fexp", fail_exp, 8'h00);
    check("sa1_fgot", fail_got, 8'h01);
    check("sa1_wr5", nwr5 - w5, 1);
    check("sa1_mem4", mem[4], 8'hFF);
    check("sa1_mem6", mem[6], 8'h00);

    // Writes to address 3 alias onto address 11
    fault = 2;
    run_bist(0, 0, dc, nd, nb);
    check("alias_done_cyc", dc, 41);
    check("alias_pass", pass, 0);
    check("alias_faddr", fail_addr, 11);
    check("alias_fexp", fail_exp, 8'h00);
    check("alias_fgot", fail_got, 8'hFF);

    // Rerun after failure, with stray starts at cycles 10 and 177
    fault = 0;
    run_bist(10, 177, dc, nd, nb);
    check("rerun_clr_pass", s_pass1, 0);
    check("rerun_clr_faddr", s_faddr1, 0);
    check("rerun_clr_fexp", s_fexp1, 0);
    check("rerun_clr_fgot", s_fgot1, 0);
    check("rerun_done_cyc", dc, 177);
    check("rerun_ndone", nd, 1);
    check("rerun_pass", pass, 1);

    // Reset in the middle of M2
    start_pulse();
    for (int i = 1; i <= 60; i++) @(negedge clk);
    check("mid_we_before", ram_we, 1);
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_we_async", ram_we, 0);
    check("mid_busy_async", busy, 0);
    w0 = wcnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_no_writes", wcnt - w0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_idle_busy", busy, 0);
    check("mid_idle_done", done, 0);
    check("mid_idle_we", ram_we, 0);
    run_bist(0, 0, dc, nd, nb);
    check("post_rst_done_cyc", dc, 177);
    check("post_rst_pass", pass, 1);
    check("post_rst_busy_cyc", nb, 176);

    check("din_zero_when_idle", din_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
